ram_responder: RTL and testbench

Memory-side responder for the SPARC datapath's RAM_enable/RAM_OpCode/MFC handshake. It accepts load and store requests from the control unit/MAR/MDR path and performs big-endian byte, halfword and word accesses on an internal byte array. After a programmable number of wait states it signals completion with MFC. It replaces the zero-latency RAM model, so control-unit wait states get real exercise.

---
 rtl/ram_responder.sv | 195 +++++++++++++++++++
 tb/tb_ram_responder.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/ram_responder.sv
// Wait-stated big-endian byte RAM answering the RAM_enable/RAM_OpCode/MFC handshake.
// Define MEM_ALIGN_CHECK_EN to reject misaligned accesses instead of aligning them down.
module ram_responder #(
    parameter int ADDR_WIDTH  = 9,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        Clk,
    input  logic        Clr,
    input  logic        RAM_enable,
    input  logic [5:0]  RAM_OpCode,
    input  logic [31:0] Address,
    input  logic [31:0] DataIn,
    output logic [31:0] DataOut,
    output logic        MFC,
    output logic        Busy,
    output logic        Align_Err
);

    localparam int MEM_BYTES = 2 ** ADDR_WIDTH;

`ifdef MEM_ALIGN_CHECK_EN
    localparam bit ALIGN_CHECK = 1'b1;
`else
    localparam bit ALIGN_CHECK = 1'b0;
`endif

    localparam logic [5:0] OP_LD   = 6'b000000;
    localparam logic [5:0] OP_LDUB = 6'b000001;
    localparam logic [5:0] OP_LDUH = 6'b000010;
    localparam logic [5:0] OP_LDSB = 6'b001001;
    localparam logic [5:0] OP_LDSH = 6'b001010;
    localparam logic [5:0] OP_ST   = 6'b000100;
    localparam logic [5:0] OP_STB  = 6'b000101;
    localparam logic [5:0] OP_STH  = 6'b000110;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;
    typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_t;

    state_t                  state_q, state_d;
    logic [5:0]              op_q, op_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [31:0]             data_q, data_d;
    logic [3:0]              cnt_q, cnt_d;
    logic [31:0]             dout_q, dout_d;
    logic                    mfc_q, mfc_d;
    logic                    align_err_q, align_err_d;

    logic [7:0]              mem [MEM_BYTES];

    logic                    is_load, is_store, sext, misaligned, access, wr_en;
    size_t                   sz;
    logic [ADDR_WIDTH-1:0]   a0, a1, a2, a3;
    logic [31:0]             rd_word, load_val, wr_word;
    logic [3:0]              wr_mask;

    // Upper address bits are deliberately dropped so accesses wrap.
    logic unused_addr_bits;
    assign unused_addr_bits = ^Address[31:ADDR_WIDTH];

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
        is_load  = 1'b0;
        is_store = 1'b0;
        sext     = 1'b0;
        sz       = SZ_W;
        case (op_q)
            OP_LD:   begin is_load  = 1'b1; sz = SZ_W; end
            OP_LDUB: begin is_load  = 1'b1; sz = SZ_B; end
            OP_LDUH: begin is_load  = 1'b1; sz = SZ_H; end
            OP_LDSB: begin is_load  = 1'b1; sz = SZ_B; sext = 1'b1; end
            OP_LDSH: begin is_load  = 1'b1; sz = SZ_H; sext = 1'b1; end
            OP_ST:   begin is_store = 1'b1; sz = SZ_W; end
            OP_STB:  begin is_store = 1'b1; sz = SZ_B; end
            OP_STH:  begin is_store = 1'b1; sz = SZ_H; end
            default: ;
        endcase
    end

    always_comb begin
        misaligned = ALIGN_CHECK && (is_load || is_store) &&
                     ((sz == SZ_W && addr_q[1:0] != 2'b00) || (sz == SZ_H && addr_q[0]));
        case (sz)
            SZ_W:    a0 = {addr_q[ADDR_WIDTH-1:2], 2'b00};
            SZ_H:    a0 = {addr_q[ADDR_WIDTH-1:1], 1'b0};
            default: a0 = addr_q;
        endcase
        a1 = a0 + ADDR_WIDTH'(1);
        a2 = a0 + ADDR_WIDTH'(2);
        a3 = a0 + ADDR_WIDTH'(3);
    end

    // Big-endian: the lowest address is the most significant byte.
    always_comb begin
        rd_word = {mem[a0], mem[a1], mem[a2], mem[a3]};
        case (sz)
            SZ_W:    load_val = rd_word;
            SZ_H:    load_val = {{16{sext & rd_word[31]}}, rd_word[31:16]};
            default: load_val = {{24{sext & rd_word[31]}}, rd_word[31:24]};
        endcase
        case (sz)
            SZ_W:    begin wr_word = data_q;                 wr_mask = 4'b1111; end
            SZ_H:    begin wr_word = {data_q[15:0], 16'h0};  wr_mask = 4'b1100; end
            default: begin wr_word = {data_q[7:0], 24'h0};   wr_mask = 4'b1000; end
        endcase
    end

    assign access = (state_q == S_WAIT) && (cnt_q == 4'd0);
    assign wr_en  = access && is_store && !misaligned;

    // NOTE: memory contents are never reset; only the control state is, which keeps this a plain RAM.
    always_ff @(posedge Clk) begin
        if (wr_en) begin
            if (wr_mask[3]) mem[a0] <= wr_word[31:24];
            if (wr_mask[2]) mem[a1] <= wr_word[23:16];
            if (wr_mask[1]) mem[a2] <= wr_word[15:8];
            if (wr_mask[0]) mem[a3] <= wr_word[7:0];
        end
    end

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        addr_d      = addr_q;
        data_d      = data_q;
        cnt_d       = cnt_q;
        dout_d      = dout_q;
        mfc_d       = mfc_q;
        align_err_d = align_err_q;
        case (state_q)
            S_IDLE: begin
                if (RAM_enable) begin
                    op_d    = RAM_OpCode;
                    addr_d  = Address[ADDR_WIDTH-1:0];
                    data_d  = DataIn;
                    cnt_d   = 4'(WAIT_CYCLES);
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) begin
                    mfc_d   = 1'b1;
                    state_d = S_DONE;
                    if (misaligned) begin
                        dout_d      = 32'h0;
                        align_err_d = 1'b1;
                    end else if (is_load) begin
                        dout_d = load_val;
                    end else if (!is_store) begin
                        dout_d = 32'h0;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_DONE: begin
                // Completion is held until the requester withdraws its enable.
                if (!RAM_enable) begin
                    mfc_d       = 1'b0;
                    align_err_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge Clk or negedge Clr) begin
        if (!Clr) begin
            state_q     <= S_IDLE;
            op_q        <= 6'h0;
            addr_q      <= '0;
            data_q      <= 32'h0;
            cnt_q       <= 4'd0;
            dout_q      <= 32'h0;
            mfc_q       <= 1'b0;
            align_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            cnt_q       <= cnt_d;
            dout_q      <= dout_d;
            mfc_q       <= mfc_d;
            align_err_q <= align_err_d;
        end
    end

    assign DataOut   = dout_q;
    assign MFC       = mfc_q;
    assign Busy      = (state_q == S_WAIT) || (state_q == S_DONE);
    assign Align_Err = align_err_q;

endmodule

// File: tb/tb_ram_responder.sv
// Bench for ram_responder: table of requests with a scoreboard queue, plus reset,
// early-enable-drop and zero-wait back-to-back sequences.
module tb_ram_responder;

    localparam int WA = 2;
    localparam int WB = 0;

`ifdef MEM_ALIGN_CHECK_EN
    localparam bit ALIGN_CHK = 1'b1;
`else
    localparam bit ALIGN_CHK = 1'b0;
`endif

    localparam logic [5:0] LD = 6'b000000, LDUB = 6'b000001, LDUH = 6'b000010;
    localparam logic [5:0] LDSB = 6'b001001, LDSH = 6'b001010;
    localparam logic [5:0] ST = 6'b000100, STB = 6'b000101, STH = 6'b000110;
    localparam logic [5:0] BAD = 6'b111111;

    typedef struct {
        logic [5:0]  op;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] exp;
        bit          chk;
        bit          exp_align;
        bit          sel;
    } vec_t;

    logic        Clk = 1'b0;
    logic        Clr;
    logic        en_a, en_b;
    logic [5:0]  RAM_OpCode;
    logic [31:0] Address, DataIn;
    logic [31:0] dout_a, dout_b;
    logic        mfc_a, mfc_b, busy_a, busy_b, align_a, align_b;

    int n_vec = 0;
    int n_err = 0;
    vec_t vecs[$];
    vec_t sb_q[$];

    ram_responder #(.ADDR_WIDTH(9), .WAIT_CYCLES(WA)) u_dut (
        .Clk(Clk), .Clr(Clr), .RAM_enable(en_a), .RAM_OpCode(RAM_OpCode),
        .Address(Address), .DataIn(DataIn), .DataOut(dout_a), .MFC(mfc_a),
        .Busy(busy_a), .Align_Err(align_a)
    );

    ram_responder #(.ADDR_WIDTH(9), .WAIT_CYCLES(WB)) u_dut0 (
        .Clk(Clk), .Clr(Clr), .RAM_enable(en_b), .RAM_OpCode(RAM_OpCode),
        .Address(Address), .DataIn(DataIn), .DataOut(dout_b), .MFC(mfc_b),
        .Busy(busy_b), .Align_Err(align_b)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic [5:0] op, input logic [31:0] addr,
                                input logic [31:0] data, input logic [31:0] exp,
                                input bit chk, input bit exp_align, input bit sel);
        vec_t v;
        v.op = op; v.addr = addr; v.data = data; v.exp = exp;
        v.chk = chk; v.exp_align = exp_align; v.sel = sel;
        return v;
    endfunction

    // Starts and ends just after a falling edge.
    task automatic do_req(input vec_t v);
        vec_t e;
        int   cyc;
        bit   seen;
        RAM_OpCode = v.op;
        Address    = v.addr;
        DataIn     = v.data;
        if (v.sel) en_b = 1'b1; else en_a = 1'b1;
        sb_q.push_back(v);
        cyc  = 0;
        seen = 1'b0;
        while (!seen && cyc < 40) begin
            @(posedge Clk);
            @(negedge Clk);
            cyc++;
            seen = v.sel ? mfc_b : mfc_a;
        end
        e = sb_q.pop_front();
        if (!seen) begin
            check("mfc_timeout", 32'd0, 32'd1);
            en_a = 1'b0;
            en_b = 1'b0;
            @(posedge Clk);
            @(negedge Clk);
            return;
        end
        check("latency", cyc, (e.sel ? WB : WA) + 2);
        if (e.chk) check("dataout", e.sel ? dout_b : dout_a, e.exp);
        check("align_err", {31'b0, e.sel ? align_b : align_a}, {31'b0, e.exp_align});
        check("busy_done", {31'b0, e.sel ? busy_b : busy_a}, 32'd1);
        @(posedge Clk);
        @(negedge Clk);
        check("mfc_hold", {31'b0, e.sel ? mfc_b : mfc_a}, 32'd1);
        if (e.chk) check("dataout_hold", e.sel ? dout_b : dout_a, e.exp);
        en_a = 1'b0;
        en_b = 1'b0;
        @(posedge Clk);
        @(negedge Clk);
        check("mfc_fall", {31'b0, e.sel ? mfc_b : mfc_a}, 32'd0);
        check("busy_idle", {31'b0, e.sel ? busy_b : busy_a}, 32'd0);
        check("align_clear", {31'b0, e.sel ? align_b : align_a}, 32'd0);
        if (e.chk) check("dataout_keep", e.sel ? dout_b : dout_a, e.exp);
    endtask

    initial begin
        int cyc;
        bit seen;
        Clr = 1'b0; en_a = 1'b0; en_b = 1'b0;
        RAM_OpCode = 6'h0; Address = 32'h0; DataIn = 32'h0;

        // Preload (0..2), then the main table (3..), then the zero-wait instance.
        vecs.push_back(mk(ST,   32'd32, 32'hDEADBEEF, 32'h0,        0, 0, 0));
        vecs.push_back(mk(ST,   32'd28, 32'hCAFEF00D, 32'h0,        0, 0, 0));
        vecs.push_back(mk(LD,   32'd32, 32'h0,        32'hDEADBEEF, 1, 0, 0));
        vecs.push_back(mk(ST,   32'd32, 32'h00000009, 32'h0,        0, 0, 0));
        vecs.push_back(mk(LD,   32'd32, 32'h0,        32'h00000009, 1, 0, 0));
        vecs.push_back(mk(STB,  32'd33, 32'h123456A5, 32'h0,        0, 0, 0));
        vecs.push_back(mk(LDSB, 32'd33, 32'h0,        32'hFFFFFFA5, 1, 0, 0));
        vecs.push_back(mk(LDUB, 32'd33, 32'h0,        32'h000000A5, 1, 0, 0));
        vecs.push_back(mk(LDSH, 32'd32, 32'h0,        32'h000000A5, 1, 0, 0));
        vecs.push_back(mk(LDUH, 32'd32, 32'h0,        32'h000000A5, 1, 0, 0));
        vecs.push_back(mk(STH,  32'd34, 32'hFFFF8001, 32'h0,        0, 0, 0));
        vecs.push_back(mk(LDSH, 32'd34, 32'h0,        32'hFFFF8001, 1, 0, 0));
        vecs.push_back(mk(LDUH, 32'd34, 32'h0,        32'h00008001, 1, 0, 0));
        vecs.push_back(mk(LDSB, 32'd34, 32'h0,        32'hFFFFFF80, 1, 0, 0));
        vecs.push_back(mk(LD,   32'd32, 32'h0,        32'h00A58001, 1, 0, 0));
        vecs.push_back(mk(BAD,  32'd32, 32'hFFFFFFFF, 32'h0,        1, 0, 0));
        vecs.push_back(mk(LD,   32'd32, 32'h0,        32'h00A58001, 1, 0, 0));
        vecs.push_back(mk(ST,   32'hFFFFFE04, 32'h01020304, 32'h0,  0, 0, 0));
        vecs.push_back(mk(LD,   32'd4,  32'h0,        32'h01020304, 1, 0, 0));
        vecs.push_back(mk(LD,   32'h204, 32'h0,       32'h01020304, 1, 0, 0));
        vecs.push_back(mk(ST,   32'd30, 32'h11223344, 32'h0,        ALIGN_CHK, ALIGN_CHK, 0));
        vecs.push_back(mk(LD,   32'd28, 32'h0, ALIGN_CHK ? 32'hCAFEF00D : 32'h11223344, 1, 0, 0));
        vecs.push_back(mk(LDUH, 32'd35, 32'h0, ALIGN_CHK ? 32'h0 : 32'h00008001, 1, ALIGN_CHK, 0));
        vecs.push_back(mk(LD,   32'd33, 32'h0, ALIGN_CHK ? 32'h0 : 32'h00A58001, 1, ALIGN_CHK, 0));
        vecs.push_back(mk(ST,   32'd8,  32'h12345678, 32'h0,        0, 0, 1));
        vecs.push_back(mk(LD,   32'd8,  32'h0,        32'h12345678, 1, 0, 1));
        vecs.push_back(mk(LDUB, 32'd9,  32'h0,        32'h00000034, 1, 0, 1));
        vecs.push_back(mk(LD,   32'd8,  32'h0,        32'h12345678, 1, 0, 1));

        #12;
        check("rst_dataout", dout_a, 32'h0);
        check("rst_mfc",  {31'b0, mfc_a},  32'd0);
        check("rst_busy", {31'b0, busy_a}, 32'd0);
        check("rst_align", {31'b0, align_a}, 32'd0);
        @(negedge Clk);
        Clr = 1'b1;
        @(negedge Clk);

        for (int i = 0; i < 3; i++) do_req(vecs[i]);

        // Reset during WAIT of a store: outputs clear at once, the store never lands.
        RAM_OpCode = ST; Address = 32'd32; DataIn = 32'h00000009; en_a = 1'b1;
        @(posedge Clk);
        @(negedge Clk);
        check("busy_wait", {31'b0, busy_a}, 32'd1);
        #2 Clr = 1'b0;
        #1;
        check("async_rst_dataout", dout_a, 32'h0);
        check("async_rst_mfc",  {31'b0, mfc_a},  32'd0);
        check("async_rst_busy", {31'b0, busy_a}, 32'd0);
        check("async_rst_align", {31'b0, align_a}, 32'd0);
        en_a = 1'b0;
        repeat (3) @(negedge Clk);
        Clr = 1'b1;
        @(negedge Clk);
        do_req(mk(LD, 32'd32, 32'h0, 32'hDEADBEEF, 1, 0, 0));

        for (int i = 3; i < 24; i++) do_req(vecs[i]);

        // Enable withdrawn after the capture edge: store still commits, MFC pulses once.
        RAM_OpCode = ST; Address = 32'd40; DataIn = 32'h77665544; en_a = 1'b1;
        @(posedge Clk);
        @(negedge Clk);
        en_a = 1'b0;
        check("busy_after_drop", {31'b0, busy_a}, 32'd1);
        cyc = 1;
        seen = mfc_a;
        while (!seen && cyc < 40) begin
            @(posedge Clk);
            @(negedge Clk);
            cyc++;
            seen = mfc_a;
        end
        check("drop_latency", cyc, WA + 2);
        @(posedge Clk);
        @(negedge Clk);
        check("drop_mfc_pulse", {31'b0, mfc_a}, 32'd0);
        check("drop_idle", {31'b0, busy_a}, 32'd0);
        do_req(mk(LD, 32'd40, 32'h0, 32'h77665544, 1, 0, 0));

        for (int i = 24; i < vecs.size(); i++) do_req(vecs[i]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
